// File: rtl/adc_capture_buffer.sv
// Triggered capture buffer for one ADC channel: converts offset binary to two's complement,
// keeps a pre/post-trigger window in on-chip RAM and streams it out over valid/ready.
module adc_capture_buffer #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 10,
    parameter int PRE    = 256
) (
    input  logic              clk,
    input  logic              areset,
    input  logic [DATA_W-1:0] adc_d,
    input  logic              adc_otr,
    input  logic              arm,
    input  logic              force_trig,
    input  logic [DATA_W-1:0] threshold,
    output logic [DATA_W-1:0] out_data,
    output logic              out_otr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              triggered
);

    // state | meaning
    // IDLE  | no writes, waiting for arm
    // FILL  | writing the first PRE samples of the window
    // WAIT  | writing continuously (wrapping), evaluating the trigger
    // POST  | writing the samples that follow the trigger sample
    // READ  | streaming DEPTH words, oldest first

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRE);
    localparam logic [ADDR_W-1:0] FILL_LOAD = ADDR_W'((PRE > 0) ? PRE - 1 : 0);
    localparam logic [ADDR_W-1:0] POST_LOAD = ADDR_W'((DEPTH - PRE > 1) ? DEPTH - PRE - 2 : 0);
    localparam logic [ADDR_W:0]   READ_LOAD = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   READ_ONE  = (ADDR_W + 1)'(1);
    localparam bit                HAS_POST  = (DEPTH - PRE - 1) > 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_WAIT,
        S_POST,
        S_READ
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] adc_q;
    logic [DATA_W-1:0] s_cur;
    logic [DATA_W-1:0] s_prev;
    logic              otr_q;
    logic              prev_ok;
    logic [ADDR_W-1:0] wp;
    logic [ADDR_W-1:0] rp;
    logic [ADDR_W-1:0] fill_cnt;
    logic [ADDR_W-1:0] post_cnt;
    logic [ADDR_W:0]   rd_left;

    logic              wr_en;
    logic              arm_go;
    logic              crossing;
    logic              trig_hit;
    logic              accept;
    logic              load_out;
    logic              rd_issue;
    logic [1:0]        occ;

    logic [DATA_W:0]   mem [DEPTH];
    logic [DATA_W:0]   ram_q;
    logic              ram_vld;
    logic              ram_last;
    logic [DATA_W:0]   skid_word;
    logic              skid_valid;
    logic              skid_last;

    always_comb begin
        s_cur    = {~adc_q[DATA_W-1], adc_q[DATA_W-2:0]};
        wr_en    = (state == S_FILL) || (state == S_WAIT) || (state == S_POST);
        arm_go   = (state == S_IDLE) && arm;
        // prev_ok masks the first comparison after arm when no FILL sample precedes it
        crossing = prev_ok
                   && ($signed(s_prev) < $signed(threshold))
                   && ($signed(s_cur) >= $signed(threshold));
        trig_hit = (state == S_WAIT) && (crossing || force_trig);
        accept   = out_valid && out_ready;
        load_out = !out_valid || out_ready;
        // words held or in flight after this edge; at most two fit (output reg + skid)
        occ      = 2'(out_valid) + 2'(skid_valid) + 2'(ram_vld) - 2'(accept);
        rd_issue = (state == S_READ) && (rd_left != '0) && (occ < 2'd2);
        busy     = (state != S_IDLE);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (arm) state_nxt = (PRE == 0) ? S_WAIT : S_FILL;
            S_FILL: if (fill_cnt == '0) state_nxt = S_WAIT;
            S_WAIT: if (trig_hit) state_nxt = HAS_POST ? S_POST : S_READ;
            S_POST: if (post_cnt == '0) state_nxt = S_READ;
            S_READ: if (accept && out_last) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state     <= S_IDLE;
            adc_q     <= '0;
            otr_q     <= 1'b0;
            s_prev    <= '0;
            prev_ok   <= 1'b0;
            wp        <= '0;
            rp        <= '0;
            fill_cnt  <= '0;
            post_cnt  <= '0;
            rd_left   <= '0;
            triggered <= 1'b0;
            ram_vld   <= 1'b0;
            ram_last  <= 1'b0;
        end else begin
            state  <= state_nxt;
            adc_q  <= adc_d;
            otr_q  <= adc_otr;
            s_prev <= s_cur;

            if (arm_go) begin
                wp        <= '0;
                fill_cnt  <= FILL_LOAD;
                prev_ok   <= 1'b0;
                triggered <= 1'b0;
            end else if (wr_en) begin
                wp      <= wp + 1'b1;
                prev_ok <= 1'b1;
            end

            if (state == S_FILL) fill_cnt <= fill_cnt - 1'b1;
            if (state == S_POST) post_cnt <= post_cnt - 1'b1;

            // oldest window word sits PRE addresses behind the trigger sample
            if (trig_hit) begin
                post_cnt  <= POST_LOAD;
                rp        <= wp - PRE_OFS;
                triggered <= 1'b1;
            end else if (rd_issue) begin
                rp <= rp + 1'b1;
            end

            if ((state != S_READ) && (state_nxt == S_READ)) rd_left <= READ_LOAD;
            else if (rd_issue) rd_left <= rd_left - 1'b1;

            ram_vld  <= rd_issue;
            ram_last <= rd_issue && (rd_left == READ_ONE);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wp] <= {otr_q, s_cur};
        if (rd_issue) ram_q <= mem[rp];
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            out_data   <= '0;
            out_otr    <= 1'b0;
            out_last   <= 1'b0;
            out_valid  <= 1'b0;
            skid_word  <= '0;
            skid_last  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (load_out) begin
            if (skid_valid) begin
                out_data   <= skid_word[DATA_W-1:0];
                out_otr    <= skid_word[DATA_W];
                out_last   <= skid_last;
                out_valid  <= 1'b1;
                skid_word  <= ram_q;
                skid_last  <= ram_last;
                skid_valid <= ram_vld;
            end else if (ram_vld) begin
                out_data  <= ram_q[DATA_W-1:0];
                out_otr   <= ram_q[DATA_W];
                out_last  <= ram_last;
                out_valid <= 1'b1;
            end else begin
                out_last  <= 1'b0;
                out_valid <= 1'b0;
            end
        end else if (ram_vld) begin
            skid_word  <= ram_q;
            skid_last  <= ram_last;
            skid_valid <= 1'b1;
        end
    end

endmodule
